noc_packetizer: RTL and testbench

Network-interface injection stage that sits directly upstream of a mesh router local port. Accepts a packet request (destination, payload length) plus a payload word stream from a processing element, and emits a flit stream of one header flit, then N body flits, on the router's receive-side valid/ready/flit/is_header/is_tail port. Output flits are registered, and full one-flit-per-cycle throughput is sustained under back-pressure.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/noc_flit_out_reg.sv | 38 +++
 rtl/noc_packetizer.sv | 118 +++++++++++
 tb/tb_noc_packetizer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and header-field offsets for NoC injection blocks.
// Header layout MSB-first: dest_x, dest_y, src_x, src_y ... len at bit 0.
package noc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_t;

    function automatic int hdr_dest_x_lsb(input int dw, input int cw);
        return dw - cw;
    endfunction

    function automatic int hdr_dest_y_lsb(input int dw, input int cw);
        return dw - 2 * cw;
    endfunction

    function automatic int hdr_src_x_lsb(input int dw, input int cw);
        return dw - 3 * cw;
    endfunction

    function automatic int hdr_src_y_lsb(input int dw, input int cw);
        return dw - 4 * cw;
    endfunction

    function automatic int hdr_used_bits(input int cw, input int lw);
        return 4 * cw + lw;
    endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// Registered flit output stage: loads a new flit whenever the slot is empty or draining.
// One-cycle latency; holds flit/is_header/is_tail stable while valid && !ready.
module noc_flit_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_flit,
    input  logic                  load_is_header,
    input  logic                  load_is_tail,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] flit,
    output logic                  is_header,
    output logic                  is_tail,
    output logic                  out_free
);

    assign out_free = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            flit      <= '0;
            is_header <= 1'b0;
            is_tail   <= 1'b0;
        end else if (out_free) begin
            valid <= load;
            if (load) begin
                flit      <= load_flit;
                is_header <= load_is_header;
                is_tail   <= load_is_tail;
            end
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Builds header + N body flits from a request and payload stream toward a router local port.
// Flit visible one cycle after fire; req/pay ready follow output-slot availability.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COORD_W    = 4,
    parameter int LEN_W      = 8,
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [COORD_W-1:0]    req_dest_x,
    input  logic [COORD_W-1:0]    req_dest_y,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  pay_valid,
    output logic                  pay_ready,
    input  logic [DATA_WIDTH-1:0] pay_data,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [15:0]           pkt_sent_cnt
);

    localparam int DX_LSB = hdr_dest_x_lsb(DATA_WIDTH, COORD_W);
    localparam int DY_LSB = hdr_dest_y_lsb(DATA_WIDTH, COORD_W);
    localparam int SX_LSB = hdr_src_x_lsb(DATA_WIDTH, COORD_W);
    localparam int SY_LSB = hdr_src_y_lsb(DATA_WIDTH, COORD_W);

    generate
        if (hdr_used_bits(COORD_W, LEN_W) > DATA_WIDTH) begin : g_hdr_too_wide
            $error("noc_packetizer: header fields do not fit in DATA_WIDTH");
        end
    endgenerate

    pkt_state_t            state;
    logic [LEN_W-1:0]      remaining;
    logic                  out_free;
    logic                  req_fire;
    logic                  pay_fire;
    logic                  load;
    logic                  load_is_tail;
    logic [DATA_WIDTH-1:0] hdr;
    logic [DATA_WIDTH-1:0] load_flit;

    assign req_ready = !noc_rst && (state == IDLE) && out_free;
    assign pay_ready = !noc_rst && (state == BODY) && out_free;
    assign req_fire  = req_valid && req_ready;
    assign pay_fire  = pay_valid && pay_ready;

    always_comb begin
        hdr                          = '0;
        hdr[DX_LSB +: COORD_W]       = req_dest_x;
        hdr[DY_LSB +: COORD_W]       = req_dest_y;
        hdr[SX_LSB +: COORD_W]       = COORD_W'(X_ID);
        hdr[SY_LSB +: COORD_W]       = COORD_W'(Y_ID);
        hdr[LEN_W-1:0]               = req_len;
    end

    assign load         = req_fire || pay_fire;
    assign load_flit    = req_fire ? hdr : pay_data;
    assign load_is_tail = req_fire ? (req_len == '0) : (remaining == LEN_W'(1));

    // remaining counts body flits still owed; it never exceeds req_len, so 255 fits.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        remaining <= req_len;
                        if (req_len != '0) state <= BODY;
                    end
                end
                BODY: begin
                    if (pay_fire) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            pkt_sent_cnt <= '0;
        end else if (sender_valid && sender_ready && sender_is_tail) begin
            pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
        end
    end

    noc_flit_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk            (noc_clk),
        .rst            (noc_rst),
        .load           (load),
        .load_flit      (load_flit),
        .load_is_header (req_fire),
        .load_is_tail   (load_is_tail),
        .ready          (sender_ready),
        .valid          (sender_valid),
        .flit           (sender_flit),
        .is_header      (sender_is_header),
        .is_tail        (sender_is_tail),
        .out_free       (out_free)
    );

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed steps plus random traffic against a stream-level reference model.
module tb_noc_packetizer;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int LW   = 8;
    localparam int XID  = 0;
    localparam int YID  = 0;

    logic          noc_clk = 1'b0;
    logic          noc_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_dest_x = '0;
    logic [CW-1:0] req_dest_y = '0;
    logic [LW-1:0] req_len = '0;
    logic          pay_valid = 1'b0;
    logic          pay_ready;
    logic [DW-1:0] pay_data = '0;
    logic          sender_valid;
    logic          sender_ready = 1'b1;
    logic [DW-1:0] sender_flit;
    logic          sender_is_header;
    logic          sender_is_tail;
    logic [15:0]   pkt_sent_cnt;

    always #5 noc_clk = ~noc_clk;

    noc_packetizer #(
        .DATA_WIDTH (DW),
        .COORD_W    (CW),
        .LEN_W      (LW),
        .X_ID       (XID),
        .Y_ID       (YID)
    ) dut (
        .noc_clk          (noc_clk),
        .noc_rst          (noc_rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_dest_x       (req_dest_x),
        .req_dest_y       (req_dest_y),
        .req_len          (req_len),
        .pay_valid        (pay_valid),
        .pay_ready        (pay_ready),
        .pay_data         (pay_data),
        .sender_valid     (sender_valid),
        .sender_ready     (sender_ready),
        .sender_flit      (sender_flit),
        .sender_is_header (sender_is_header),
        .sender_is_tail   (sender_is_tail),
        .pkt_sent_cnt     (pkt_sent_cnt)
    );

    typedef struct {
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        logic [LW-1:0] len;
    } req_t;

    typedef struct {
        logic [DW-1:0] flit;
        logic          h;
        logic          t;
    } exp_t;

    int checks = 0;
    int errors = 0;

    req_t          req_src[$];
    logic [DW-1:0] pay_src[$];
    exp_t          exp_q[$];
    int            owed = 0;
    int            exp_cnt = 0;
    int            nout = 0;
    bit            rnd_mode = 1'b0;
    logic          sready_force = 1'b1;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_flit = '0;
    logic          prev_h = 1'b0;
    logic          prev_t = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr_of(input req_t r);
        return (32'(r.dx) << 28) | (32'(r.dy) << 24) | (32'(XID) << 20) |
               (32'(YID) << 16) | 32'(r.len);
    endfunction

    task automatic push_req(input int dx, input int dy, input int len);
        req_t r;
        r.dx  = CW'(dx);
        r.dy  = CW'(dy);
        r.len = LW'(len);
        req_src.push_back(r);
    endtask

    task automatic push_rand_pkt(input int len);
        push_req($urandom_range(0, 15), $urandom_range(0, 15), len);
        for (int i = 0; i < len; i++) pay_src.push_back($urandom);
    endtask

    task automatic set_inputs();
        if (req_src.size() > 0) begin
            req_valid  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            req_dest_x = req_src[0].dx;
            req_dest_y = req_src[0].dy;
            req_len    = req_src[0].len;
        end else begin
            req_valid = 1'b0;
        end
        if (pay_src.size() > 0) begin
            pay_valid = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            pay_data  = pay_src[0];
        end else begin
            pay_valid = 1'b0;
        end
        sender_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : sready_force;
    endtask

    // One clock: score the cycle at the falling edge, then drive fresh inputs after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge noc_clk);
        if (noc_rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_pay_ready", pay_ready, 0);
            prev_stall = 1'b0;
        end else begin
            chk("pkt_cnt", pkt_sent_cnt, 64'(exp_cnt % 65536));
            if (prev_stall) begin
                chk("stall_flit", sender_flit, prev_flit);
                chk("stall_hdr", sender_is_header, prev_h);
                chk("stall_tail", sender_is_tail, prev_t);
            end
            if (sender_valid && !sender_ready) begin
                chk("stall_req_ready", req_ready, 0);
                chk("stall_pay_ready", pay_ready, 0);
            end
            prev_stall = sender_valid && !sender_ready;
            prev_flit  = sender_flit;
            prev_h     = sender_is_header;
            prev_t     = sender_is_tail;
            if (sender_valid && sender_ready) begin
                nout++;
                if (exp_q.size() == 0) begin
                    chk("extra_flit", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_flit", sender_flit, e.flit);
                    chk("out_hdr", sender_is_header, e.h);
                    chk("out_tail", sender_is_tail, e.t);
                    if (e.t) exp_cnt++;
                end
            end
            if (req_valid && req_ready) begin
                chk("req_mid_packet", owed, 0);
                e.flit = hdr_of(req_src[0]);
                e.h    = 1'b1;
                e.t    = (req_src[0].len == 0);
                exp_q.push_back(e);
                owed = int'(req_src[0].len);
                void'(req_src.pop_front());
            end
            if (pay_valid && pay_ready) begin
                chk("pay_while_idle", owed > 0, 1);
                e.flit = pay_data;
                e.h    = 1'b0;
                e.t    = (owed == 1);
                exp_q.push_back(e);
                if (owed > 0) owed--;
                void'(pay_src.pop_front());
            end
        end
        @(posedge noc_clk);
        #1;
        set_inputs();
    endtask

    task automatic run(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (req_src.size() == 0 && pay_src.size() == 0 && exp_q.size() == 0 &&
                owed == 0 && !sender_valid) begin
                done = 1'b1;
                break;
            end
            cyc();
        end
        chk("drain_timeout", done, 1);
    endtask

    task automatic reset_dut();
        noc_rst = 1'b1;
        set_inputs();
        cyc();
        chk("rst_valid", sender_valid, 0);
        chk("rst_cnt", pkt_sent_cnt, 0);
        noc_rst = 1'b0;
        exp_q.delete();
        req_src.delete();
        pay_src.delete();
        owed       = 0;
        exp_cnt    = 0;
        prev_stall = 1'b0;
        set_inputs();
        #1;
    endtask

    initial begin
        int vcnt;
        bit contiguous;

        // Reset state
        reset_dut();
        chk("rst_state", {sender_valid, sender_is_header, sender_is_tail, sender_flit, pkt_sent_cnt},
            64'd0);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_pay_ready", pay_ready, 0);

        // len=3 packet to (1,1)
        push_req(1, 1, 3);
        pay_src.push_back(32'hA0);
        pay_src.push_back(32'hA1);
        pay_src.push_back(32'hA2);
        set_inputs();
        cyc();
        chk("t1_hdr", {sender_valid, sender_is_header, sender_is_tail, sender_flit}, {3'b110, 32'h11000003});
        cyc();
        chk("t1_a0", {sender_valid, sender_is_header, sender_is_tail, sender_flit}, {3'b100, 32'hA0});
        cyc();
        chk("t1_a1", {sender_valid, sender_is_header, sender_is_tail, sender_flit}, {3'b100, 32'hA1});
        cyc();
        chk("t1_a2", {sender_valid, sender_is_header, sender_is_tail, sender_flit}, {3'b101, 32'hA2});
        cyc();
        chk("t1_cnt", pkt_sent_cnt, 1);
        chk("t1_idle", sender_valid, 0);

        // Zero-length packet; a stray payload word must stay unconsumed
        pay_src.push_back(32'hDEADBEEF);
        push_req(0, 1, 0);
        set_inputs();
        cyc();
        chk("t2_flit", {sender_valid, sender_is_header, sender_is_tail, sender_flit}, {3'b111, 32'h01000000});
        chk("t2_pay_ready", pay_ready, 0);
        cyc();
        cyc();
        chk("t2_pay_kept", pay_src.size(), 1);
        chk("t2_cnt", pkt_sent_cnt, 2);
        pay_src.delete();
        set_inputs();

        // Five-cycle stall mid-body
        nout = 0;
        push_req(2, 3, 4);
        for (int i = 0; i < 4; i++) pay_src.push_back(32'hB0 + 32'(i));
        set_inputs();
        cyc();
        cyc();
        sready_force = 1'b0;
        set_inputs();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_hold_flit", sender_flit, 32'hB0);
            chk("t3_hold_pay_ready", pay_ready, 0);
        end
        sready_force = 1'b1;
        set_inputs();
        run(100);
        chk("t3_nflits", nout, 5);

        // Back-to-back len=2 packets
        push_rand_pkt(2);
        push_rand_pkt(2);
        set_inputs();
        vcnt = 0;
        contiguous = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (sender_valid) vcnt++;
            if (i < 6 && !sender_valid) contiguous = 1'b0;
            if (i == 3) chk("t4_second_hdr", sender_valid && sender_is_header, 1);
        end
        chk("t4_valid_cycles", vcnt, 6);
        chk("t4_contiguous", contiguous, 1);
        run(20);

        // Random traffic, random backpressure
        rnd_mode = 1'b1;
        for (int p = 0; p < 40; p++) push_rand_pkt($urandom_range(0, 6));
        set_inputs();
        run(3000);
        rnd_mode = 1'b0;
        set_inputs();

        // Reset mid-packet, then a fresh packet
        push_rand_pkt(5);
        set_inputs();
        cyc();
        cyc();
        cyc();
        chk("t5_mid_body", sender_valid && !sender_is_header, 1);
        reset_dut();
        nout = 0;
        push_rand_pkt(2);
        set_inputs();
        run(50);
        chk("t5_nflits", nout, 3);
        chk("t5_cnt", pkt_sent_cnt, 1);

        // Counter wrap
        reset_dut();
        for (int p = 0; p < 65535; p++) push_rand_pkt(0);
        set_inputs();
        run(70000);
        chk("t6_cnt_max", pkt_sent_cnt, 16'hFFFF);
        push_rand_pkt(0);
        set_inputs();
        run(10);
        chk("t6_cnt_wrap", pkt_sent_cnt, 0);

        // Maximum length packet
        nout = 0;
        push_rand_pkt(255);
        set_inputs();
        run(1000);
        chk("t7_nflits", nout, 256);
        chk("t7_cnt", pkt_sent_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
